// File: rtl/split_stream_using_double_buffer_and_fifos.sv
// split_stream_using_double_buffer_and_fifos: 2-entry input skid buffer forking {b,a} words into two independent FIFOs
module split_stream_using_double_buffer_and_fifos #(
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*width-1:0]         in_data,
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [width-1:0]           a_data,
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [width-1:0]           b_data,
  output logic [$clog2(depth+1)-1:0] a_level,
  output logic [$clog2(depth+1)-1:0] b_level
);
  localparam int lw = $clog2(depth+1);
  localparam int pw = $clog2(depth);
  logic [2*width-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]         cnt_q, cnt_d, slot;
  logic               in_ready_q, push, fire;
  logic [1:0]         full, pop, rdy;
  logic [width-1:0]   mem_q [2][depth];
  logic [pw-1:0]      wr_q [2];
  logic [pw-1:0]      rd_q [2];
  logic [lw-1:0]      lvl_q [2];
  assign push     = in_valid & in_ready_q;
  assign fire     = (cnt_q != 2'd0) & ~full[0] & ~full[1];
  assign rdy      = {b_ready, a_ready};
  assign in_ready = in_ready_q;
  // incoming word lands in the first free slot after the head has (possibly) shifted out
  always_comb begin
    slot   = cnt_q - {1'b0, fire};
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, fire};
    buf0_d = (push && slot == 2'd0) ? in_data : fire ? buf1_q : buf0_q;
    buf1_d = (push && slot == 2'd1) ? in_data : buf1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      in_ready_q <= cnt_d != 2'd2;
    end
  end
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i] = lvl_q[i] == lw'(depth);
      pop[i]  = (lvl_q[i] != '0) & rdy[i];
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        lvl_q[i] <= '0;
      end else begin
        if (fire) begin
          mem_q[i][wr_q[i]] <= buf0_q[i*width +: width];
          wr_q[i]           <= wr_q[i] == pw'(depth-1) ? '0 : wr_q[i] + 1'b1;
        end
        if (pop[i]) rd_q[i] <= rd_q[i] == pw'(depth-1) ? '0 : rd_q[i] + 1'b1;
        lvl_q[i] <= lvl_q[i] + lw'(fire) - lw'(pop[i]);
      end
    end
  end
  assign a_valid = lvl_q[0] != '0;
  assign b_valid = lvl_q[1] != '0;
  assign a_data  = a_valid ? mem_q[0][rd_q[0]] : '0;
  assign b_data  = b_valid ? mem_q[1][rd_q[1]] : '0;
  assign a_level = lvl_q[0];
  assign b_level = lvl_q[1];
endmodule

// File: tb/tb_split_stream_using_double_buffer_and_fifos.sv
// tb_split_stream_using_double_buffer_and_fifos: directed checks of the fork stage against a queue scoreboard
module tb_split_stream_using_double_buffer_and_fifos;
  logic        clk = 0, rst = 1, in_valid = 0, a_ready = 0, b_ready = 0;
  logic [15:0] in_data = '0;
  logic        in_ready, a_valid, b_valid;
  logic [7:0]  a_data, b_data;
  logic [3:0]  a_level, b_level;
  int          n_cmp = 0, n_err = 0, acc = 0, pa = 0, pb = 0, nxt = 0, stalls = 0;
  logic [7:0]  qa[$], qb[$];

  split_stream_using_double_buffer_and_fifos #(.width(8), .depth(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .a_level(a_level), .b_level(b_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // record the handshakes that the coming posedge will perform, then advance to the next negedge
  task automatic cyc();
    if (!rst) begin
      if (a_valid && a_ready) begin
        pa++;
        if (qa.size() == 0) chk("a_extra", 32'(a_data), 32'hdead);
        else chk("a_data", 32'(a_data), 32'(qa.pop_front()));
      end
      if (b_valid && b_ready) begin
        pb++;
        if (qb.size() == 0) chk("b_extra", 32'(b_data), 32'hdead);
        else chk("b_data", 32'(b_data), 32'(qb.pop_front()));
      end
      if (in_valid && in_ready) begin
        qa.push_back(in_data[7:0]);
        qb.push_back(in_data[15:8]);
        acc++;
        nxt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_data  = {8'(nxt) + 8'h80, 8'(nxt)};
      cyc();
    end
    in_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
    qa.delete();
    qb.delete();
    acc = 0; pa = 0; pb = 0; nxt = 0;
  endtask

  initial begin
    // reset held two cycles with in_valid asserted
    in_valid = 1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    chk("rst_a_level", 32'(a_level), 0);
    chk("rst_b_level", 32'(b_level), 0);
    chk("rst_a_data", 32'(a_data), 0);
    in_valid = 0;
    rst = 0;
    // single word latency
    in_valid = 1;
    in_data  = 16'h0305;
    cyc();
    in_valid = 0;
    chk("lat_early", 32'(a_valid), 0);
    cyc();
    chk("one_a_valid", 32'(a_valid), 1);
    chk("one_b_valid", 32'(b_valid), 1);
    chk("one_a_data", 32'(a_data), 32'h05);
    chk("one_b_data", 32'(b_data), 32'h03);
    chk("one_a_level", 32'(a_level), 1);
    chk("one_b_level", 32'(b_level), 1);
    a_ready = 1; b_ready = 1;
    cyc();
    a_ready = 0; b_ready = 0;
    chk("one_drained", 32'(a_level) + 32'(b_level), 0);
    // both consumers stalled: exactly depth+2 words absorbed
    do_reset();
    feed(30);
    chk("stall_acc", 32'(acc), 12);
    chk("stall_in_ready", 32'(in_ready), 0);
    chk("stall_a_level", 32'(a_level), 10);
    chk("stall_b_level", 32'(b_level), 10);
    a_ready = 1; b_ready = 1;
    repeat (20) cyc();
    chk("stall_pa", 32'(pa), 12);
    chk("stall_pb", 32'(pb), 12);
    a_ready = 0; b_ready = 0;
    // skew: a drains freely, b blocks the fork once full
    do_reset();
    a_ready = 1;
    feed(30);
    chk("skew_acc", 32'(acc), 12);
    chk("skew_pa", 32'(pa), 10);
    chk("skew_a_level", 32'(a_level), 0);
    chk("skew_b_level", 32'(b_level), 10);
    chk("skew_in_ready", 32'(in_ready), 0);
    b_ready = 1;
    repeat (30) cyc();
    chk("skew_pa_all", 32'(pa), 12);
    chk("skew_pb_all", 32'(pb), 12);
    chk("skew_levels", 32'(a_level) + 32'(b_level), 0);
    // full throughput with random data
    do_reset();
    a_ready = 1; b_ready = 1;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1;
      in_data  = 16'($urandom);
      if (!in_ready) stalls++;
      cyc();
    end
    in_valid = 0;
    repeat (2) cyc();
    chk("tput_acc", 32'(acc), 100);
    chk("tput_stalls", 32'(stalls), 0);
    chk("tput_pa", 32'(pa), 100);
    chk("tput_pb", 32'(pb), 100);
    chk("tput_levels", 32'(a_level) + 32'(b_level), 0);
    // reset mid-traffic at levels 5/7
    do_reset();
    a_ready = 0; b_ready = 0;
    for (int i = 0; i < 20 && acc < 7; i++) feed(1);
    repeat (2) cyc();
    a_ready = 1;
    repeat (2) cyc();
    a_ready = 0;
    chk("mid_a_level", 32'(a_level), 5);
    chk("mid_b_level", 32'(b_level), 7);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_valid", {30'd0, a_valid, b_valid}, 0);
    chk("mid_rst_levels", 32'(a_level) + 32'(b_level), 0);
    chk("mid_rst_data", {16'd0, a_data, b_data}, 0);
    rst = 0;
    qa.delete();
    qb.delete();
    in_valid = 1;
    in_data  = 16'hA1B2;
    cyc();
    in_valid = 0;
    cyc();
    chk("post_a_data", 32'(a_data), 32'hB2);
    chk("post_b_data", 32'(b_data), 32'hA1);
    a_ready = 1; b_ready = 1;
    repeat (5) cyc();
    chk("post_valid", {30'd0, a_valid, b_valid}, 0);
    chk("post_levels", 32'(a_level) + 32'(b_level), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
